// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU datapath, program RAM and RAM loader.
package cpu_pkg;

    localparam int RAM_DATA_W = 8;
    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DEPTH  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_VERIFY,
        S_DONE,
        S_ERROR
    } ram_loader_state_t;

endpackage

// File: rtl/ram_loader_sum.sv
// WIDTH-bit modulo-2**WIDTH accumulator with synchronous clear (priority) and enable.
module ram_loader_sum #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] sum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
        end else if (clr) begin
            sum_reg <= '0;
        end else if (en) begin
            sum_reg <= sum_reg + din;
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/ram_loader.sv
// Streams 2**ADDR_W bytes into the program RAM over a valid/ready handshake while holding the CPU off.
// Define RAM_LOADER_VERIFY_EN to add a trailing checksum byte and a readback verify pass.
module ram_loader
    import cpu_pkg::*;
#(
    parameter int WIDTH  = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_wdata,
    input  logic [WIDTH-1:0]  ram_rdata,
    output logic              ram_prog_en,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   load_count
);

    localparam int                DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

    ram_loader_state_t state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   load_count_reg;
    logic              start_accept;
    logic              in_load;
    logic              in_verify;

    assign in_load      = (state_reg == S_LOAD);
    assign in_verify    = (state_reg == S_VERIFY);
    assign start_accept = start && (state_reg == S_IDLE || state_reg == S_DONE ||
                                    state_reg == S_ERROR);

`ifdef RAM_LOADER_VERIFY_EN
    logic [WIDTH-1:0] wr_sum;
    logic [WIDTH-1:0] rb_sum;
    logic [WIDTH-1:0] rb_final;
    logic [WIDTH-1:0] checksum_reg;

    ram_loader_sum #(.WIDTH(WIDTH)) u_wr_sum (
        .clk (clk),
        .rst (rst),
        .clr (start_accept),
        .en  (in_load && in_valid),
        .din (in_data),
        .sum (wr_sum)
    );

    ram_loader_sum #(.WIDTH(WIDTH)) u_rb_sum (
        .clk (clk),
        .rst (rst),
        .clr (start_accept),
        .en  (in_verify),
        .din (ram_rdata),
        .sum (rb_sum)
    );

    // Include the byte on the bus this cycle so the last readback takes part in the compare.
    assign rb_final = rb_sum + ram_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_reg <= '0;
        end else if (state_reg == S_CHECK && in_valid) begin
            checksum_reg <= in_data;
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            load_count_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_reg      <= S_LOAD;
                        addr_reg       <= '0;
                        load_count_reg <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        addr_reg <= addr_reg + 1'b1;
                        if (load_count_reg != COUNT_FULL) begin
                            load_count_reg <= load_count_reg + 1'b1;
                        end
                        if (addr_reg == LAST_ADDR) begin
`ifdef RAM_LOADER_VERIFY_EN
                            state_reg <= S_CHECK;
`else
                            state_reg <= S_DONE;
`endif
                        end
                    end
                end
`ifdef RAM_LOADER_VERIFY_EN
                S_CHECK: begin
                    if (in_valid) begin
                        addr_reg  <= '0;
                        state_reg <= S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    addr_reg <= addr_reg + 1'b1;
                    if (addr_reg == LAST_ADDR) begin
                        if (rb_final == wr_sum && rb_final == checksum_reg) begin
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_ERROR;
                        end
                    end
                end
`endif
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Only the write strobe and write data see the source combinationally.
    assign in_ready    = in_load || (state_reg == S_CHECK);
    assign ram_prog_en = in_load;
    assign ram_wr_en   = in_load && in_valid;
    assign ram_wdata   = in_load ? in_data : '0;
    assign ram_addr    = (in_load || in_verify) ? addr_reg : '0;
    assign cpu_hold    = in_load || (state_reg == S_CHECK) || in_verify ||
                         (state_reg == S_ERROR);
    assign done        = (state_reg == S_DONE);
    assign load_count  = load_count_reg;

`ifdef RAM_LOADER_VERIFY_EN
    assign ram_rd_en = in_verify;
    assign error     = (state_reg == S_ERROR);
`else
    assign ram_rd_en = 1'b0;
    assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Directed self-checking bench for ram_loader with a behavioural 16 x 8 program RAM.
module tb_ram_loader;

`ifdef RAM_LOADER_VERIFY_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 17;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       ram_prog_en;
    logic       ram_wr_en;
    logic       ram_rd_en;
    logic       cpu_hold;
    logic       done;
    logic       error;
    logic [4:0] load_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;
    int excl_bad = 0;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    ram_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .ram_prog_en (ram_prog_en),
        .ram_wr_en   (ram_wr_en),
        .ram_rd_en   (ram_rd_en),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error),
        .load_count  (load_count)
    );

    // Program RAM model: writes on the program path, combinational read onto the bus.
    always @(posedge clk) begin
        if (ram_prog_en && ram_wr_en) begin
            mem[ram_addr] <= ram_wdata;
            n_writes++;
        end
    end
    assign ram_rdata = ram_rd_en ? mem[ram_addr] : 8'h00;

    always @(negedge clk) begin
        if (!rst && ((ram_wr_en && ram_rd_en) || (ram_wr_en && !ram_prog_en)))
            excl_bad++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_end(inout int cyc);
        for (int k = 0; k < 80 && !(done || error); k++) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({done, error, cpu_hold, in_ready} !== 4'b0000)
            $display("FAIL reset_flags got %b want 0000", {done, error, cpu_hold, in_ready});
        else n_pass++;
        n_checks++;
        if ({ram_prog_en, ram_wr_en, ram_rd_en, ram_addr, ram_wdata, load_count} !== '0)
            $display("FAIL reset_ram got addr=%h wdata=%h cnt=%0d ctl=%b want all 0",
                     ram_addr, ram_wdata, load_count, {ram_prog_en, ram_wr_en, ram_rd_en});
        else n_pass++;
        rst = 1'b0;
        tick();
        $display("reset: done=%b cpu_hold=%b load_count=%0d", done, cpu_hold, load_count);
    endtask

    task automatic test_plain_load;
        int cyc;
        int bad;
        bad = 0;
        n_writes = 0;
        do_start();
        cyc = 1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            #1;
            if (ram_addr !== 4'(i) || !ram_wr_en || !ram_prog_en || !in_ready ||
                !cpu_hold || ram_wdata !== 8'(i) || done)
                bad++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad != 0) $display("FAIL plain_stream got %0d bad cycles want 0", bad);
        else n_pass++;
`ifdef RAM_LOADER_VERIFY_EN
        n_checks++;
        if (!in_ready || !cpu_hold || done)
            $display("FAIL plain_check_state got ready=%b hold=%b done=%b want 1 1 0",
                     in_ready, cpu_hold, done);
        else n_pass++;
        send_byte(8'h78);
        cyc++;
`endif
        wait_end(cyc);
        n_checks++;
        if (done !== 1'b1 || cyc != LAT)
            $display("FAIL plain_latency got done=%b at %0d want done=1 at %0d", done, cyc, LAT);
        else n_pass++;
        n_checks++;
        if (cpu_hold !== 1'b0 || error !== 1'b0)
            $display("FAIL plain_hold got hold=%b error=%b want 0 0", cpu_hold, error);
        else n_pass++;
        n_checks++;
        if (load_count !== 5'd16 || n_writes != 16)
            $display("FAIL plain_count got cnt=%0d writes=%0d want 16 16", load_count, n_writes);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== 8'(i)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL plain_mem got %0d wrong words want 0", bad);
        else n_pass++;
        $display("plain_load: done at cycle %0d, writes=%0d", cyc, n_writes);
    endtask

    task automatic test_stall;
        int cyc;
        int bad;
        bad = 0;
        n_writes = 0;
        do_start();
        cyc = 1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            #1;
            if (ram_wr_en || ram_addr !== 4'(i) || load_count !== 5'(i)) bad++;
            tick();
            if (ram_addr !== 4'(i)) bad++;
            send_byte(8'hA0 + 8'(i));
            cyc += 2;
        end
        n_checks++;
        if (bad != 0) $display("FAIL stall_gaps got %0d bad gap samples want 0", bad);
        else n_pass++;
`ifdef RAM_LOADER_VERIFY_EN
        tick();
        n_checks++;
        if (!in_ready || done) $display("FAIL stall_check_wait got ready=%b done=%b want 1 0",
                                        in_ready, done);
        else n_pass++;
        send_byte(8'h78);
`endif
        wait_end(cyc);
        n_checks++;
        if (n_writes != 16 || done !== 1'b1)
            $display("FAIL stall_writes got writes=%0d done=%b want 16 1", n_writes, done);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== 8'hA0 + 8'(i)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL stall_mem got %0d wrong words want 0", bad);
        else n_pass++;
        $display("stall: writes=%0d done=%b", n_writes, done);
    endtask

    task automatic test_reset_mid_load;
        int cyc;
        do_start();
        for (int i = 0; i < 7; i++) send_byte(8'h30 + 8'(i));
        n_checks++;
        if (load_count !== 5'd7 || ram_addr !== 4'd7)
            $display("FAIL midrst_pre got cnt=%0d addr=%0d want 7 7", load_count, ram_addr);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, cpu_hold, ram_prog_en, ram_addr, load_count, done} !== '0)
            $display("FAIL midrst_async got ready=%b hold=%b prog=%b addr=%0d cnt=%0d want 0",
                     in_ready, cpu_hold, ram_prog_en, ram_addr, load_count);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (mem[6] !== 8'h36 || mem[7] !== 8'hA7)
            $display("FAIL midrst_mem got m6=%h m7=%h want 36 a7", mem[6], mem[7]);
        else n_pass++;
        do_start();
        in_valid = 1'b1;
        in_data  = 8'h55;
        #1;
        n_checks++;
        if (ram_addr !== 4'd0 || load_count !== 5'd0 || !ram_wr_en)
            $display("FAIL midrst_restart got addr=%0d cnt=%0d wr=%b want 0 0 1",
                     ram_addr, load_count, ram_wr_en);
        else n_pass++;
        for (int i = 0; i < 16; i++) send_byte(8'h55);
`ifdef RAM_LOADER_VERIFY_EN
        send_byte(8'h50);
`endif
        cyc = 0;
        wait_end(cyc);
        n_checks++;
        if (done !== 1'b1 || mem[0] !== 8'h55 || mem[15] !== 8'h55)
            $display("FAIL midrst_reload got done=%b m0=%h m15=%h want 1 55 55",
                     done, mem[0], mem[15]);
        else n_pass++;
        $display("reset_mid_load: reload done=%b", done);
    endtask

    task automatic test_ignored_start;
        int cyc;
        do_start();
        for (int i = 0; i < 5; i++) send_byte(8'(i));
        start = 1'b1;
        send_byte(8'h05);
        start = 1'b0;
        n_checks++;
        if (load_count !== 5'd6 || ram_addr !== 4'd6 || !in_ready)
            $display("FAIL ignstart_load got cnt=%0d addr=%0d ready=%b want 6 6 1",
                     load_count, ram_addr, in_ready);
        else n_pass++;
        for (int i = 6; i < 16; i++) send_byte(8'(i));
`ifdef RAM_LOADER_VERIFY_EN
        send_byte(8'h78);
`endif
        cyc = 0;
        wait_end(cyc);
        // Start while DONE begins a fresh load.
        do_start();
        n_checks++;
        if (done !== 1'b0 || !in_ready || load_count !== 5'd0 || !cpu_hold)
            $display("FAIL restart_done got done=%b ready=%b cnt=%0d hold=%b want 0 1 0 1",
                     done, in_ready, load_count, cpu_hold);
        else n_pass++;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
`ifdef RAM_LOADER_VERIFY_EN
        send_byte(8'h78);
`endif
        cyc = 0;
        wait_end(cyc);
        $display("ignored_start: done=%b", done);
    endtask

`ifdef RAM_LOADER_VERIFY_EN
    task automatic test_verify(input logic [7:0] csum, input logic exp_ok);
        int cyc;
        do_start();
        for (int i = 0; i < 16; i++) send_byte(8'h11);
        send_byte(csum);
        n_checks++;
        if (!ram_rd_en || ram_wr_en || ram_addr !== 4'd0 || in_ready)
            $display("FAIL verify_rd got rd=%b wr=%b addr=%0d ready=%b want 1 0 0 0",
                     ram_rd_en, ram_wr_en, ram_addr, in_ready);
        else n_pass++;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (!ram_rd_en || ram_addr !== 4'd3)
            $display("FAIL verify_ignstart got rd=%b addr=%0d want 1 3", ram_rd_en, ram_addr);
        else n_pass++;
        cyc = 0;
        wait_end(cyc);
        n_checks++;
        if (done !== exp_ok || error !== !exp_ok || cpu_hold !== !exp_ok)
            $display("FAIL verify_result csum=%h got done=%b err=%b hold=%b want %b %b %b",
                     csum, done, error, cpu_hold, exp_ok, !exp_ok, !exp_ok);
        else n_pass++;
        $display("verify csum=%h: done=%b error=%b", csum, done, error);
        if (!exp_ok) begin
            do_start();
            n_checks++;
            if (error !== 1'b0 || !in_ready || load_count !== 5'd0)
                $display("FAIL restart_error got err=%b ready=%b cnt=%0d want 0 1 0",
                         error, in_ready, load_count);
            else n_pass++;
            for (int i = 0; i < 16; i++) send_byte(8'h11);
            send_byte(8'h10);
            cyc = 0;
            wait_end(cyc);
        end
    endtask
`endif

    task automatic test_exclusivity;
        n_checks++;
        if (excl_bad != 0) $display("FAIL exclusivity got %0d bad cycles want 0", excl_bad);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        test_reset();
        test_reset_mid_load();
        test_plain_load();
        test_stall();
        test_ignored_start();
`ifdef RAM_LOADER_VERIFY_EN
        test_verify(8'h10, 1'b1);
        test_verify(8'h11, 1'b0);
`endif
        test_exclusivity();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
# ram_loader

Sequencing controller for the 16 x 8 program RAM. It accepts a stream of bytes over a valid/ready handshake and writes them to addresses 0..15 in order, using the RAM's program path. While it loads, it holds the CPU off the bus. It sits between the byte source (switch debouncer or serial receiver) and the RAM's `prog_en`/`wr_en`/`rd_en`/`addr` inputs, and replaces manual switch programming.

## Interface
- `WIDTH`, 8, data width of the RAM and the byte stream
- `ADDR_W`, 4, RAM address width; depth is 2**ADDR_W
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a load; one-cycle pulse
- `in_data`  in  WIDTH  byte from the source
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  loader accepts a byte this cycle
- `ram_addr`  out  ADDR_W  RAM address (overrides the MAR during a load)
- `ram_wdata`  out  WIDTH  drives the RAM switch input
- `ram_rdata`  in  WIDTH  RAM bus value during readback
- `ram_prog_en`, `ram_wr_en`, `ram_rd_en`  out  1  RAM controls
- `cpu_hold`  out  1  CPU must not drive the bus or use the RAM
- `done`  out  1  load completed successfully; level
- `error`  out  1  checksum mismatch; level
- `load_count`  out  ADDR_W+1  bytes written in the current or last load

## Operation
- States: IDLE, LOAD, CHECK, VERIFY, DONE, ERROR.
- IDLE:
  - all outputs 0.
  - `start` -> LOAD; clears the address counter, `load_count` and the running sum.
- LOAD:
  - `in_ready`=1, `ram_prog_en`=1, `cpu_hold`=1.
  - `ram_addr` = counter; `ram_wdata` = `in_data`.
  - `ram_wr_en` = `in_valid` (combinational), so the write commits on the handshake edge.
  - Each handshake: counter+1, `load_count`+1, sum += `in_data` mod 2**WIDTH.
  - Handshake at address 15 -> CHECK if verify is compiled in, else DONE.
- CHECK:
  - `in_ready`=1, no RAM write.
  - On handshake, the byte is latched as the expected checksum; counter cleared -> VERIFY.
- VERIFY:
  - `ram_rd_en`=1, `ram_addr` = counter.
  - Each cycle: `ram_rdata` added to the readback sum; counter+1.
  - After address 15, compare the readback sum with both the write-time sum and the checksum. Both equal -> DONE, else ERROR.
- DONE: `done`=1, `cpu_hold`=0.
- ERROR: `error`=1, `cpu_hold`=1.
- `start` in DONE or ERROR restarts a load (-> LOAD, `done`/`error` cleared). `start` in LOAD, CHECK or VERIFY is ignored.
- Counter wraps 15 -> 0 only at the phase transition. `load_count` saturates at 16.
- `in_valid` low in LOAD/CHECK stalls indefinitely; nothing else changes.
- `ram_wr_en` and `ram_rd_en` are never high in the same cycle.

## Timing
- Reset value of every output is 0; state returns to IDLE immediately on `rst`.
- RAM contents are not touched by reset. A load interrupted by reset leaves memory partially written.
- Throughput: one byte per cycle in LOAD with `in_valid` held high.
- Latency, start pulse to DONE:
  - 17 cycles without verify (1 + 16 bytes).
  - 34 cycles with verify (1 + 16 + 1 + 16).
- `in_ready`, `ram_*` and `cpu_hold` are decoded from the registered state, with no input-to-output path except `ram_wr_en` <- `in_valid` and `ram_wdata` <- `in_data`.
- `done`/`error` assert the cycle after the final handshake (no verify) or after the final readback (verify).

## Configuration
- `RAM_LOADER_VERIFY_EN` defined:
  - CHECK and VERIFY states exist.
  - A 17th checksum byte is expected.
  - ERROR is reachable.
- Undefined:
  - LOAD -> DONE directly.
  - `error` is tied 0, `ram_rd_en` is tied 0, and no sum registers are built.

## Structure
- Shared package `cpu_pkg`:
  - state enum `ram_loader_state_t`.
  - `RAM_DEPTH` = 16.
  - width constants reused by the MAR and RAM.
- Sub-module `ram_loader_sum`: WIDTH-bit modulo accumulator with clear and enable, instanced twice when verify is compiled in (write sum, readback sum).

## Test plan
- **Plain load:** reset; `start`; stream 0x00..0x0F back-to-back. Expect:
  - writes to addresses 0..15.
  - `done`=1 at cycle 17 (34 with verify, checksum 0x78).
  - `cpu_hold` falls with `done`.
- **Stalled source:** `in_valid` toggled every other cycle. Expect: one write per handshake only, `ram_addr` frozen during gaps, correct final contents.
- **Verify pass/fail:**
  - bytes all 0x11 with checksum 0x10 -> DONE.
  - same bytes with checksum 0x11 -> ERROR, `cpu_hold`=1.
- **Reset mid-load:** assert `rst` after 7 bytes. Expect all outputs 0 and IDLE the same cycle; a second `start` begins again at address 0.
- **Ignored start:** `start` pulses during LOAD and VERIFY have no effect; `start` in ERROR begins a new load with `error` cleared.
- **Exclusivity:** assertion over all tests that `ram_wr_en` and `ram_rd_en` are never high together and that `ram_wr_en` implies `ram_prog_en`.
